seletor_tiro_inimigo: RTL
=========================

Name: seletor_tiro_inimigo

Overview:
- Enemy fire scheduler. Decides when an enemy shoots and which enemy fires.
- Consumes the alive-enemy vector and drives the enemy-shot row/column IDs. The top level uses those IDs to index posX/posY and spawn the enemy munition.
- Picks a pseudo-random starting column, then chooses the bottom-most live enemy in it. Empty columns are skipped with wrap-around.
- Shots are rate-limited by an interval timer and gated by munition availability.

Parameters:
- COLUNAS, 13, enemy columns.
- LINHAS, 5, enemy rows; row LINHAS-1 is the bottom row (largest posY).
- INTERVALO, 5_000_000, clock cycles between shot attempts (24-bit).
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- habilitar  in  1  1 = game in progress (state 1); 0 aborts and holds idle.
- vivo_inimigo  in  COLUNAS*LINHAS  alive flags; index = linha*COLUNAS + coluna.
- tiro_livre  in  1  1 = enemy munition free (off-screen), a new shot may be issued.
- disparo  out  1  one-cycle pulse; IDs valid in the same cycle.
- id_coluna  out  6  column of the chosen shooter (held until next disparo).
- id_linha  out  6  row of the chosen shooter (held).
- id_inimigo  out  7  linha*COLUNAS + coluna (held).
- ocupado  out  1  1 while in SORTEIA/VARRE/DISPARA.
- sem_alvo  out  1  sticky; set when a full scan finds no live enemy; cleared on the next successful disparo or reset.

Behaviour:
- Reset (clk edge with reset=1), output values:
  - disparo=0, IDs=0, ocupado=0, sem_alvo=0.
  - FSM in ESPERA.
  - timer loaded with INTERVALO-1.
  - LFSR loaded with LFSR_SEED.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Every clock: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Free-running regardless of habilitar.
- ESPERA:
  - If habilitar=1 and timer != 0: decrement the timer.
  - When timer == 0 and tiro_livre=1: latch cand = lfsr[5:0] and go to SORTEIA.
  - When timer == 0 and tiro_livre=0: hold at 0 (no retrigger counting) until tiro_livre rises.
- SORTEIA (modulo reduction, 1 to 5 cycles):
  - If cand >= COLUNAS: cand <= cand - COLUNAS, stay.
  - Otherwise: col <= cand, col_ini <= cand, linha <= LINHAS-1, go to VARRE.
- VARRE (one cell per cycle):
  - If vivo_inimigo[linha*COLUNAS+col] = 1: latch IDs, go to DISPARA.
  - Else if linha == 0: linha <= LINHAS-1 and col <= (col == COLUNAS-1) ? 0 : col+1.
    - If the new col equals col_ini: set sem_alvo, reload the timer, go to ESPERA with no pulse.
  - Else: linha <= linha-1.
  - Worst case COLUNAS*LINHAS cycles.
- DISPARA:
  - disparo=1 for exactly one cycle, sem_alvo <= 0.
  - Reload timer with INTERVALO-1, go to ESPERA.
- Latency, trigger to disparo: 1 (enter SORTEIA) + reduction cycles + scan cycles + 1.
- vivo_inimigo is sampled live during VARRE. An enemy killed mid-scan is simply not chosen.
- habilitar=0 in any state:
  - Next state is ESPERA, timer reloaded, no disparo.
  - IDs and sem_alvo keep their values.
- Timer reload is always INTERVALO-1 (period INTERVALO cycles of habilitar=1).
- All arithmetic is unsigned. id_inimigo is computed at latch time and fits in 7 bits (max 64).

Optional Feature:
- Macro: SELETOR_MIRA_EN.
- When defined:
  - Adds input coluna_mira [5:0] (column under the player ship, from the top level).
  - A 1-bit toggle flips on each disparo.
  - When toggle=1, SORTEIA takes cand = min(coluna_mira, COLUNAS-1) instead of lfsr[5:0].
  - Scan rules are unchanged.
  - Toggle resets to 0, so the first shot is random.
- When undefined: no coluna_mira port, and every shot uses the LFSR.

Test Plan:
- Bench uses INTERVALO=10.
- Reset, habilitar=1, tiro_livre=1, only enemy 30 alive (linha 2, col 4) -> exactly one disparo within 10+5+65+1 cycles; id_coluna=4, id_linha=2, id_inimigo=30; disparo high 1 cycle; next disparo no earlier than 10 cycles later.
- All 65 alive -> every disparo reports id_linha=4; id_coluna matches the reference model of lfsr[5:0] mod 13 at the SORTEIA entry cycle (seed 0xACE1).
- vivo_inimigo all zero -> no disparo; sem_alvo rises after a 65-cell scan; then set bit 0 -> next attempt fires id_inimigo=0 and sem_alvo clears.
- tiro_livre=0 at timer expiry for 50 cycles -> no disparo and ocupado=0; tiro_livre 0->1 -> SORTEIA entered on the next cycle and disparo follows.
- Drop habilitar mid-VARRE, then reassert -> no disparo during the drop; after reassert the full INTERVALO elapses before the next attempt; assert reset mid-VARRE -> all outputs 0 next cycle.
- With SELETOR_MIRA_EN, coluna_mira=20, all alive -> 2nd disparo has id_coluna=12, id_linha=4.

Source files
------------

// File: rtl/seletor_tiro_inimigo.sv
// Enemy fire scheduler: interval timer, LFSR start column, bottom-most live enemy scan.
// Define SELETOR_MIRA_EN to make every other shot aim at coluna_mira.
module seletor_tiro_inimigo #(
    parameter int          COLUNAS   = 13,
    parameter int          LINHAS    = 5,
    parameter int          INTERVALO = 5_000_000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      habilitar,
    input  logic [COLUNAS*LINHAS-1:0] vivo_inimigo,
    input  logic                      tiro_livre,
`ifdef SELETOR_MIRA_EN
    input  logic [5:0]                coluna_mira,
`endif
    output logic                      disparo,
    output logic [5:0]                id_coluna,
    output logic [5:0]                id_linha,
    output logic [6:0]                id_inimigo,
    output logic                      ocupado,
    output logic                      sem_alvo
);
    localparam logic [23:0] RECARGA = 24'(INTERVALO - 1);
    localparam logic [5:0]  NCOL    = 6'(COLUNAS);
    localparam logic [5:0]  COL_MAX = 6'(COLUNAS - 1);
    localparam logic [5:0]  LIN_MAX = 6'(LINHAS - 1);

    typedef enum logic [1:0] {
        ESPERA,
        SORTEIA,
        VARRE,
        DISPARA
    } estado_t;

    estado_t     estado;
    logic [23:0] timer;
    logic [15:0] lfsr;
    logic [5:0]  cand;
    logic [5:0]  cand_ini;
    logic [5:0]  col;
    logic [5:0]  col_ini;
    logic [5:0]  col_prox;
    logic [5:0]  linha;
    logic [6:0]  idx;
    logic        toggle;

    assign idx      = 7'(linha) * 7'(COLUNAS) + 7'(col);
    assign col_prox = (col == COL_MAX) ? 6'd0 : col + 6'd1;
    assign ocupado  = (estado != ESPERA);

`ifdef SELETOR_MIRA_EN
    assign cand_ini = !toggle ? lfsr[5:0] :
                      (coluna_mira > COL_MAX) ? COL_MAX : coluna_mira;
`else
    assign cand_ini = lfsr[5:0];
`endif

    always_ff @(posedge clk) begin
        if (reset)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= ESPERA;
            timer      <= RECARGA;
            cand       <= '0;
            col        <= '0;
            col_ini    <= '0;
            linha      <= '0;
            disparo    <= 1'b0;
            id_coluna  <= '0;
            id_linha   <= '0;
            id_inimigo <= '0;
            sem_alvo   <= 1'b0;
            toggle     <= 1'b0;
        end else begin
            disparo <= 1'b0;
            if (!habilitar) begin
                estado <= ESPERA;
                timer  <= RECARGA;
            end else begin
                unique case (estado)
                    ESPERA: begin
                        if (timer != 24'd0) begin
                            timer <= timer - 24'd1;
                        end else if (tiro_livre) begin
                            cand   <= cand_ini;
                            estado <= SORTEIA;
                        end
                    end
                    SORTEIA: begin
                        // Modulo by repeated subtraction; cand is at most 63.
                        if (cand >= NCOL) begin
                            cand <= cand - NCOL;
                        end else begin
                            col     <= cand;
                            col_ini <= cand;
                            linha   <= LIN_MAX;
                            estado  <= VARRE;
                        end
                    end
                    VARRE: begin
                        if (vivo_inimigo[idx]) begin
                            id_coluna  <= col;
                            id_linha   <= linha;
                            id_inimigo <= idx;
                            disparo    <= 1'b1;
                            sem_alvo   <= 1'b0;
                            toggle     <= ~toggle;
                            estado     <= DISPARA;
                        end else if (linha == 6'd0) begin
                            linha <= LIN_MAX;
                            col   <= col_prox;
                            if (col_prox == col_ini) begin
                                sem_alvo <= 1'b1;
                                timer    <= RECARGA;
                                estado   <= ESPERA;
                            end
                        end else begin
                            linha <= linha - 6'd1;
                        end
                    end
                    DISPARA: begin
                        timer  <= RECARGA;
                        estado <= ESPERA;
                    end
                    default: estado <= ESPERA;
                endcase
            end
        end
    end
endmodule
